// File: rtl/br_pkg.sv
// Shared types and sizing helpers for the branch resolver.
// Entry layout {pred, pc4, tgt} is shared by the resolver and its FIFO.
package br_pkg;

  localparam int BR_DEF_DEPTH  = 4;
  localparam int BR_DEF_ADDR_W = 32;

  // One in-flight predicted branch, most significant field first.
  typedef struct packed {
    logic                     pred;
    logic [BR_DEF_ADDR_W-1:0] pc4;
    logic [BR_DEF_ADDR_W-1:0] tgt;
  } br_entry_t;

  // Bits needed to hold an occupancy count of 0..depth.
  function automatic int br_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/br_fifo.sv
// Small circular FIFO holding in-flight branches in program order.
// Head is read combinationally so the resolver can compare with zero latency.
// clear discards all contents and takes priority over push and pop.
module br_fifo
  import br_pkg::*;
#(
  parameter int DEPTH = BR_DEF_DEPTH,
  parameter int WIDTH = 2 * BR_DEF_ADDR_W + 1,
  parameter int CW    = br_cnt_w(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             clear,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr_reg, wr_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             push_ok, pop_ok;

  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign head    = mem[rd_ptr_reg];
  assign count   = count_reg;
  assign push_ok = push && !full && !clear;
  assign pop_ok  = pop && !empty && !clear;

  // Entry storage; contents need no reset because count gates validity.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr_reg] <= push_data;
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (clear) begin
      rd_ptr_reg <= wr_ptr_reg;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      count_reg <= count_reg + CW'(push_ok) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/branch_resolver.sv
// Resolves predicted branches against EX outcomes in program order,
// feeds the 2-bit predictor update, and raises flush/redirect on mispredict.
// Optional statistics counters are built when BR_STATS_EN is defined.
module branch_resolver
  import br_pkg::*;
#(
  parameter int DEPTH  = BR_DEF_DEPTH,
  parameter int ADDR_W = BR_DEF_ADDR_W,
  parameter int CNT_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              issue_valid_i,
  input  logic              issue_pred_i,
  input  logic [ADDR_W-1:0] issue_pc4_i,
  input  logic [ADDR_W-1:0] issue_tgt_i,
  output logic              issue_ready_o,
  input  logic              resolve_valid_i,
  input  logic              resolve_taken_i,
  output logic              update_o,
  output logic              result_o,
  output logic              flush_o,
  output logic [ADDR_W-1:0] redirect_pc_o,
  output logic              err_o,
  output logic [CNT_W-1:0]  br_cnt_o,
  output logic [CNT_W-1:0]  mispred_cnt_o
);

  localparam int ENTRY_W = 2 * ADDR_W + 1;
  localparam int FCNT_W  = br_cnt_w(DEPTH);

  logic               fifo_push, fifo_pop, fifo_clear, fifo_full, fifo_empty;
  logic [ENTRY_W-1:0] fifo_head;
  logic [FCNT_W-1:0]  fifo_count;
  logic               head_pred;
  logic [ADDR_W-1:0]  head_pc4, head_tgt;
  logic               resolve_ok, mispredict;
  logic               err_reg, err_next;

  br_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W),
    .CW    (FCNT_W)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push      (fifo_push),
    .push_data ({issue_pred_i, issue_pc4_i, issue_tgt_i}),
    .pop       (fifo_pop),
    .clear     (fifo_clear),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  assign head_pred     = fifo_head[ENTRY_W-1];
  assign head_pc4      = fifo_head[2*ADDR_W-1:ADDR_W];
  assign head_tgt      = fifo_head[ADDR_W-1:0];
  // Readiness comes from registered occupancy only, never from a same-cycle pop.
  assign issue_ready_o = (fifo_count != FCNT_W'(DEPTH));
  assign err_o         = err_reg;

  // Zero-latency compare of the head entry with the EX outcome.
  always_comb begin
    resolve_ok    = resolve_valid_i && !fifo_empty;
    mispredict    = 1'b0;
    update_o      = 1'b0;
    result_o      = 1'b0;
    redirect_pc_o = '0;
    if (resolve_ok) begin
      mispredict    = (head_pred != resolve_taken_i);
      update_o      = 1'b1;
      result_o      = resolve_taken_i;
      redirect_pc_o = resolve_taken_i ? head_tgt : head_pc4;
    end
    flush_o    = mispredict;
    fifo_pop   = resolve_ok;
    fifo_clear = mispredict;
    // A same-cycle issue on a mispredict is wrong-path and is dropped.
    fifo_push  = issue_valid_i && issue_ready_o && !mispredict;
    // Resolving nothing, or issuing into a full FIFO, is a protocol error;
    // the full-drop on a mispredict cycle is expected and not flagged.
    err_next   = err_reg
               | (resolve_valid_i && fifo_empty)
               | (issue_valid_i && fifo_full && !mispredict);
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) err_reg <= 1'b0;
    else       err_reg <= err_next;
  end

`ifdef BR_STATS_EN
  logic [CNT_W-1:0] br_cnt_reg, mispred_cnt_reg;

  // Resolved-branch and mispredict counters, wrapping modulo 2^CNT_W.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      br_cnt_reg      <= '0;
      mispred_cnt_reg <= '0;
    end else begin
      if (resolve_ok) br_cnt_reg      <= br_cnt_reg + CNT_W'(1);
      if (mispredict) mispred_cnt_reg <= mispred_cnt_reg + CNT_W'(1);
    end
  end

  assign br_cnt_o      = br_cnt_reg;
  assign mispred_cnt_o = mispred_cnt_reg;
`else
  assign br_cnt_o      = '0;
  assign mispred_cnt_o = '0;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Self-checking bench for branch_resolver with a queue-based reference model.
module tb_branch_resolver;
  import br_pkg::*;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 32;
  localparam int CNT_W  = 32;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              issue_valid_i, issue_pred_i;
  logic [ADDR_W-1:0] issue_pc4_i, issue_tgt_i;
  logic              issue_ready_o;
  logic              resolve_valid_i, resolve_taken_i;
  logic              update_o, result_o, flush_o;
  logic [ADDR_W-1:0] redirect_pc_o;
  logic              err_o;
  logic [CNT_W-1:0]  br_cnt_o, mispred_cnt_o;

  always #5 clk_i = ~clk_i;

  branch_resolver #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .issue_valid_i   (issue_valid_i),
    .issue_pred_i    (issue_pred_i),
    .issue_pc4_i     (issue_pc4_i),
    .issue_tgt_i     (issue_tgt_i),
    .issue_ready_o   (issue_ready_o),
    .resolve_valid_i (resolve_valid_i),
    .resolve_taken_i (resolve_taken_i),
    .update_o        (update_o),
    .result_o        (result_o),
    .flush_o         (flush_o),
    .redirect_pc_o   (redirect_pc_o),
    .err_o           (err_o),
    .br_cnt_o        (br_cnt_o),
    .mispred_cnt_o   (mispred_cnt_o)
  );

  int checks = 0;
  int passes = 0;

  // Reference model state: in-flight branches in program order.
  br_entry_t         q[$];
  logic              m_err;
  logic [CNT_W-1:0]  m_br, m_mis;
  logic              e_ready, e_update, e_result, e_flush;
  logic [ADDR_W-1:0] e_redirect;
  logic [CNT_W-1:0]  e_br, e_mis;

  task automatic model_reset();
    q.delete();
    m_err = 1'b0;
    m_br  = '0;
    m_mis = '0;
  endtask

  // Expected combinational outputs for the current inputs and model state.
  task automatic model_eval();
    e_ready    = (q.size() != DEPTH);
    e_update   = 1'b0;
    e_result   = 1'b0;
    e_flush    = 1'b0;
    e_redirect = '0;
    if (resolve_valid_i && q.size() != 0) begin
      e_update   = 1'b1;
      e_result   = resolve_taken_i;
      e_flush    = (q[0].pred != resolve_taken_i);
      e_redirect = resolve_taken_i ? q[0].tgt : q[0].pc4;
    end
`ifdef BR_STATS_EN
    e_br  = m_br;
    e_mis = m_mis;
`else
    e_br  = '0;
    e_mis = '0;
`endif
  endtask

  // State change of the model at a clock edge.
  task automatic model_commit();
    if (resolve_valid_i && q.size() == 0) m_err = 1'b1;
    if (issue_valid_i && !e_ready && !e_flush) m_err = 1'b1;
    if (e_update) begin
      m_br = m_br + 1;
      if (e_flush) begin
        m_mis = m_mis + 1;
        q.delete();
      end else begin
        void'(q.pop_front());
      end
    end
    if (issue_valid_i && e_ready && !e_flush)
      q.push_back('{pred: issue_pred_i, pc4: issue_pc4_i, tgt: issue_tgt_i});
  endtask

  task automatic drive(input logic iv, input logic ip, input logic [ADDR_W-1:0] pc4,
                       input logic [ADDR_W-1:0] tgt, input logic rv, input logic rt);
    @(negedge clk_i);
    issue_valid_i   = iv;
    issue_pred_i    = ip;
    issue_pc4_i     = pc4;
    issue_tgt_i     = tgt;
    resolve_valid_i = rv;
    resolve_taken_i = rt;
    #1;
    model_eval();
  endtask

  task automatic tick();
    @(posedge clk_i);
    model_commit();
    $display("txn t=%0t iv=%0b pred=%0b pc4=%h tgt=%h rv=%0b taken=%0b upd=%0b flush=%0b redir=%h inflight=%0d",
             $time, issue_valid_i, issue_pred_i, issue_pc4_i, issue_tgt_i,
             resolve_valid_i, resolve_taken_i, update_o, flush_o, redirect_pc_o, q.size());
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    issue_valid_i   = 1'b0;
    resolve_valid_i = 1'b0;
    rst_i = 1'b1;
    model_reset();
    #2;
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i           = 1'b1;
    issue_valid_i   = 1'b0;
    issue_pred_i    = 1'b0;
    issue_pc4_i     = '0;
    issue_tgt_i     = '0;
    resolve_valid_i = 1'b1;
    resolve_taken_i = 1'b1;
    model_reset();
    #12;
    checks++; if (issue_ready_o !== 1'b1) $display("FAIL reset_ready got %0b want 1", issue_ready_o); else passes++;
    checks++; if (update_o !== 1'b0) $display("FAIL reset_update got %0b want 0", update_o); else passes++;
    checks++; if (flush_o !== 1'b0) $display("FAIL reset_flush got %0b want 0", flush_o); else passes++;
    checks++; if (redirect_pc_o !== '0) $display("FAIL reset_redirect got %h want 0", redirect_pc_o); else passes++;
    checks++; if (err_o !== 1'b0) $display("FAIL reset_err got %0b want 0", err_o); else passes++;
    checks++; if ({br_cnt_o, mispred_cnt_o} !== '0) $display("FAIL reset_cnt got %h/%h want 0", br_cnt_o, mispred_cnt_o); else passes++;
    @(negedge clk_i);
    rst_i = 1'b0;
    resolve_valid_i = 1'b0;
  endtask

  task automatic test_correct();
    drive(1, 1, 'h104, 'h200, 0, 0);
    tick();
    drive(0, 0, 0, 0, 1, 1);
    checks++; if (update_o !== 1'b1) $display("FAIL correct_update got %0b want 1", update_o); else passes++;
    checks++; if (result_o !== 1'b1) $display("FAIL correct_result got %0b want 1", result_o); else passes++;
    checks++; if (flush_o !== 1'b0) $display("FAIL correct_flush got %0b want 0", flush_o); else passes++;
    tick();
    drive(0, 0, 0, 0, 0, 0);
    checks++; if ({issue_ready_o, update_o} !== 2'b10) $display("FAIL correct_idle got %b want 10", {issue_ready_o, update_o}); else passes++;
  endtask

  task automatic test_mispredict();
    drive(1, 0, 'h104, 'h200, 0, 0);
    tick();
    drive(0, 0, 0, 0, 1, 1);
    checks++; if (flush_o !== 1'b1) $display("FAIL mis_t_flush got %0b want 1", flush_o); else passes++;
    checks++; if (redirect_pc_o !== 32'h200) $display("FAIL mis_t_redirect got %h want 200", redirect_pc_o); else passes++;
    tick();
    drive(1, 1, 'h108, 'h300, 0, 0);
    tick();
    drive(0, 0, 0, 0, 1, 0);
    checks++; if (flush_o !== 1'b1) $display("FAIL mis_nt_flush got %0b want 1", flush_o); else passes++;
    checks++; if (redirect_pc_o !== 32'h108) $display("FAIL mis_nt_redirect got %h want 108", redirect_pc_o); else passes++;
    checks++; if (result_o !== 1'b0) $display("FAIL mis_nt_result got %0b want 0", result_o); else passes++;
    tick();
  endtask

  task automatic test_full();
    logic [ADDR_W-1:0] want;
    for (int i = 0; i < 4; i++) begin
      drive(1, i[0], 32'h1000 + i * 8, 32'h2000 + i * 16, 0, 0);
      tick();
    end
    drive(1, 1, 'h5000, 'h6000, 0, 0);
    checks++; if (issue_ready_o !== 1'b0) $display("FAIL full_ready got %0b want 0", issue_ready_o); else passes++;
    tick();
    drive(0, 0, 0, 0, 0, 0);
    checks++; if (err_o !== 1'b1) $display("FAIL full_err got %0b want 1", err_o); else passes++;
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 1, i[0]);
      want = i[0] ? 32'h2000 + i * 16 : 32'h1000 + i * 8;
      checks++;
      if (redirect_pc_o !== want || flush_o !== 1'b0)
        $display("FAIL full_pop%0d got redir=%h flush=%0b want redir=%h flush=0", i, redirect_pc_o, flush_o, want);
      else passes++;
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      drive(1, 1, 32'h3000 + i * 4, 32'h4000 + i * 4, 0, 0);
      tick();
      drive(0, 0, 0, 0, 1, 1);
      want = 32'h4000 + i * 4;
      checks++;
      if ({update_o, flush_o} !== 2'b10 || redirect_pc_o !== want)
        $display("FAIL wrap_pair%0d got upd=%0b flush=%0b redir=%h want 1/0/%h", i, update_o, flush_o, redirect_pc_o, want);
      else passes++;
      tick();
    end
  endtask

  task automatic test_flush_with_issue();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 32'h8000 + i * 4, 32'h9000 + i * 4, 0, 0);
      tick();
    end
    drive(1, 1, 'h7000, 'h7100, 1, 0);
    checks++; if ({flush_o, redirect_pc_o} !== {1'b1, 32'h8000}) $display("FAIL fwi_flush got %0b/%h want 1/8000", flush_o, redirect_pc_o); else passes++;
    tick();
    drive(0, 0, 0, 0, 0, 0);
    checks++; if ({err_o, issue_ready_o} !== 2'b01) $display("FAIL fwi_err_ready got %b want 01", {err_o, issue_ready_o}); else passes++;
    drive(0, 0, 0, 0, 1, 1);
    checks++; if ({update_o, flush_o} !== 2'b00) $display("FAIL empty_resolve got %b want 00", {update_o, flush_o}); else passes++;
    tick();
    drive(0, 0, 0, 0, 0, 0);
    checks++; if (err_o !== 1'b1) $display("FAIL empty_err got %0b want 1", err_o); else passes++;
    tick();
    drive(0, 0, 0, 0, 0, 0);
    checks++; if (err_o !== 1'b1) $display("FAIL err_sticky got %0b want 1", err_o); else passes++;
  endtask

  task automatic test_async_reset();
    do_reset();
    drive(0, 0, 0, 0, 1, 0);
    tick();
    drive(1, 0, 'ha104, 'ha200, 0, 0);
    tick();
    drive(1, 0, 'ha108, 'ha300, 0, 0);
    tick();
    drive(0, 0, 0, 0, 1, 1);
    checks++; if ({flush_o, err_o} !== 2'b11) $display("FAIL ar_pre got %b want 11", {flush_o, err_o}); else passes++;
    #1;
    rst_i = 1'b1;
    model_reset();
    #1;
    checks++;
    if ({issue_ready_o, err_o, flush_o, update_o} !== 4'b1000 || redirect_pc_o !== '0)
      $display("FAIL ar_now got rdy/err/flush/upd=%b redir=%h want 1000/0", {issue_ready_o, err_o, flush_o, update_o}, redirect_pc_o);
    else passes++;
    @(negedge clk_i);
    rst_i = 1'b0;
    resolve_valid_i = 1'b0;
  endtask

  task automatic test_stats();
    logic [CNT_W-1:0] want_br, want_mis;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(1, 1, 32'hb000 + i * 4, 32'hc000 + i * 4, 0, 0);
      tick();
      drive(0, 0, 0, 0, 1, (i == 2 || i == 5 || i == 8) ? 1'b0 : 1'b1);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0);
`ifdef BR_STATS_EN
    want_br  = 10;
    want_mis = 3;
`else
    want_br  = 0;
    want_mis = 0;
`endif
    checks++; if (br_cnt_o !== want_br) $display("FAIL stats_br got %0d want %0d", br_cnt_o, want_br); else passes++;
    checks++; if (mispred_cnt_o !== want_mis) $display("FAIL stats_mis got %0d want %0d", mispred_cnt_o, want_mis); else passes++;
  endtask

  task automatic test_random();
    logic rt;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      if (q.size() != 0 && $urandom_range(3) != 0) rt = q[0].pred;
      else rt = 1'($urandom_range(1));
      drive(1'($urandom_range(2) != 0), 1'($urandom_range(1)), $urandom, $urandom,
            1'($urandom_range(2) == 0), rt);
      checks++;
      if ({issue_ready_o, update_o, result_o, flush_o, redirect_pc_o, err_o, br_cnt_o, mispred_cnt_o} !==
          {e_ready, e_update, e_result, e_flush, e_redirect, m_err, e_br, e_mis})
        $display("FAIL rand%0d got rdy=%0b upd=%0b res=%0b fl=%0b redir=%h err=%0b br=%0d mis=%0d want %0b %0b %0b %0b %h %0b %0d %0d",
                 n, issue_ready_o, update_o, result_o, flush_o, redirect_pc_o, err_o, br_cnt_o, mispred_cnt_o,
                 e_ready, e_update, e_result, e_flush, e_redirect, m_err, e_br, e_mis);
      else passes++;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_correct();
    test_mispredict();
    test_full();
    test_flush_with_issue();
    test_async_reset();
    test_stats();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
